// File: rtl/scs8hd_o31a_bist.sv
// Built-in self-test driver/checker for a single O31A cell, X = B1 & (A1|A2|A3).
// Sweeps all 16 input codes LOOPS times, samples the cell output after a settle
// window, and records the mismatch count, the first failing code and a PASS flag.
module scs8hd_o31a_bist #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned LOOPS      = 1,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             CLK,
    input  logic             RESETB,
    input  logic             START,
    input  logic             ABORT,
    input  logic             X_IN,
    output logic             A1,
    output logic             A2,
    output logic             A3,
    output logic             B1,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [3:0]       FIRST_FAIL_CODE,
    output logic             FIRST_FAIL_VALID
);

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSettle,
        StSample,
        StNext,
        StFinish
    } state_e;

    // Settle counter is loaded with SETTLE_CYC-1 so SETTLE lasts exactly SETTLE_CYC cycles.
    localparam logic [3:0]       SettleLast = 4'(SETTLE_CYC - 1);
    localparam logic [7:0]       LastLoop   = 8'(LOOPS - 1);
    localparam logic [ERR_W-1:0] ErrMax     = '1;
    localparam logic [ERR_W-1:0] ErrOne     = ERR_W'(1);

    state_e           state_q;
    logic [3:0]       code_q;
    logic [7:0]       loop_q;
    logic [3:0]       settle_q;
    logic [3:0]       drive_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [ERR_W-1:0] err_q;
    logic [3:0]       ff_code_q;
    logic             ff_valid_q;
    logic             exp_x;

    // Expected cell response for the code currently being driven.
    always_comb begin
        exp_x = code_q[3] & (code_q[0] | code_q[1] | code_q[2]);
    end

    // Sequencer FSM; every output is a flop updated here.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q    <= StIdle;
            code_q     <= '0;
            loop_q     <= '0;
            settle_q   <= '0;
            drive_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            ff_code_q  <= '0;
            ff_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != StIdle && ABORT) begin
                // Abort keeps partial error results but never reports completion.
                state_q <= StIdle;
                drive_q <= '0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (START && !ABORT) begin
                            state_q    <= StDrive;
                            busy_q     <= 1'b1;
                            code_q     <= '0;
                            loop_q     <= '0;
                            err_q      <= '0;
                            ff_code_q  <= '0;
                            ff_valid_q <= 1'b0;
                            pass_q     <= 1'b0;
                        end
                    end
                    StDrive: begin
                        drive_q  <= code_q;
                        settle_q <= SettleLast;
                        state_q  <= StSettle;
                    end
                    StSettle: begin
                        if (settle_q == 4'd0) begin
                            state_q <= StSample;
                        end else begin
                            settle_q <= settle_q - 4'd1;
                        end
                    end
                    StSample: begin
                        if (X_IN != exp_x) begin
                            if (err_q != ErrMax) begin
                                err_q <= err_q + ErrOne;
                            end
                            if (!ff_valid_q) begin
                                ff_code_q  <= code_q;
                                ff_valid_q <= 1'b1;
                            end
                        end
                        state_q <= StNext;
                    end
                    StNext: begin
                        if (code_q != 4'd15) begin
                            code_q  <= code_q + 4'd1;
                            state_q <= StDrive;
                        end else if (loop_q < LastLoop) begin
                            loop_q  <= loop_q + 8'd1;
                            code_q  <= '0;
                            state_q <= StDrive;
                        end else begin
                            state_q <= StFinish;
                        end
                    end
                    StFinish: begin
                        done_q  <= 1'b1;
                        pass_q  <= (err_q == '0);
                        drive_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                        drive_q <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign A1               = drive_q[0];
    assign A2               = drive_q[1];
    assign A3               = drive_q[2];
    assign B1               = drive_q[3];
    assign BUSY             = busy_q;
    assign DONE             = done_q;
    assign PASS             = pass_q;
    assign ERR_CNT          = err_q;
    assign FIRST_FAIL_CODE  = ff_code_q;
    assign FIRST_FAIL_VALID = ff_valid_q;

endmodule

// File: tb/tb_scs8hd_o31a_bist.sv
// Self-checking bench for scs8hd_o31a_bist: fault-mask table, randomized fault
// masks against a sweep-level model, and hand sequences for abort/restart/reset.
module tb_scs8hd_o31a_bist;

    logic CLK = 1'b0;
    logic RESETB = 1'b0;

    // Default instance: SETTLE_CYC=2, LOOPS=1, ERR_W=8.
    logic       start0 = 1'b0;
    logic       abort0 = 1'b0;
    logic       x0;
    logic       a1_0, a2_0, a3_0, b1_0, busy0, done0, pass0, ffv0;
    logic [7:0] err0;
    logic [3:0] ffc0;
    logic [15:0] xmask = 16'h0000;

    // Multi-loop instances with the cell output stuck at 0.
    logic       start_m = 1'b0;
    logic       abort_m = 1'b0;
    logic       x_m = 1'b0;
    logic       a1_3, a2_3, a3_3, b1_3, busy3, done3, pass3, ffv3;
    logic [7:0] err3;
    logic [3:0] ffc3;
    logic       a1_4, a2_4, a3_4, b1_4, busy4, done4, pass4, ffv4;
    logic [3:0] err4;
    logic [3:0] ffc4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    scs8hd_o31a_bist dut (
        .CLK(CLK), .RESETB(RESETB), .START(start0), .ABORT(abort0), .X_IN(x0),
        .A1(a1_0), .A2(a2_0), .A3(a3_0), .B1(b1_0), .BUSY(busy0), .DONE(done0),
        .PASS(pass0), .ERR_CNT(err0), .FIRST_FAIL_CODE(ffc0), .FIRST_FAIL_VALID(ffv0)
    );

    scs8hd_o31a_bist #(.SETTLE_CYC(2), .LOOPS(3), .ERR_W(8)) dut_l3 (
        .CLK(CLK), .RESETB(RESETB), .START(start_m), .ABORT(abort_m), .X_IN(x_m),
        .A1(a1_3), .A2(a2_3), .A3(a3_3), .B1(b1_3), .BUSY(busy3), .DONE(done3),
        .PASS(pass3), .ERR_CNT(err3), .FIRST_FAIL_CODE(ffc3), .FIRST_FAIL_VALID(ffv3)
    );

    scs8hd_o31a_bist #(.SETTLE_CYC(2), .LOOPS(3), .ERR_W(4)) dut_sat (
        .CLK(CLK), .RESETB(RESETB), .START(start_m), .ABORT(abort_m), .X_IN(x_m),
        .A1(a1_4), .A2(a2_4), .A3(a3_4), .B1(b1_4), .BUSY(busy4), .DONE(done4),
        .PASS(pass4), .ERR_CNT(err4), .FIRST_FAIL_CODE(ffc4), .FIRST_FAIL_VALID(ffv4)
    );

    // Cell model: a correct O31A, with the response inverted for codes set in xmask.
    logic [3:0] drv0;
    always_comb begin
        drv0 = {b1_0, a3_0, a2_0, a1_0};
        x0   = (drv0[3] & (drv0[0] | drv0[1] | drv0[2])) ^ xmask[drv0];
    end

    typedef struct {
        logic [15:0] mask;
        int          exp_err;
        int          exp_first;
        int          exp_valid;
        int          exp_pass;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Sweep-level model: each faulted code is one mismatch; lowest faulted code fails first.
    task automatic model(input logic [15:0] mask, output int err, output int first,
                         output int valid);
        err = 0;
        first = 0;
        valid = 0;
        for (int c = 0; c < 16; c++) begin
            if (mask[c]) begin
                err++;
                if (valid == 0) begin
                    first = c;
                    valid = 1;
                end
            end
        end
        if (err > 255) err = 255;
    endtask

    // Start one run on the default instance and wait for DONE; returns DONE cycle or -1.
    task automatic run0(input logic [15:0] mask, input bit check_codes, input int restart_at,
                        output int done_at);
        xmask   = mask;
        done_at = -1;
        start0  = 1'b1;
        tick();
        start0 = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            tick();
            start0 = (n == restart_at);
            if (done0) begin
                done_at = n;
                break;
            end
            if (check_codes && (n % 5) == 3 && n < 80) begin
                check($sformatf("drive_code_c%0d", n), drv0, n / 5);
            end
        end
        start0 = 1'b0;
    endtask

    initial begin
        vec_t vecs[5];
        int   done_at;
        int   e_err, e_first, e_valid;
        logic [15:0] m;

        vecs[0] = '{16'h0000, 0, 0, 0, 1};  // correct cell
        vecs[1] = '{16'hFE00, 7, 9, 1, 0};  // X stuck at 0: codes 9..15 fail
        vecs[2] = '{16'h01FF, 9, 0, 1, 0};  // X stuck at 1: codes 0..8 fail
        vecs[3] = '{16'h0010, 1, 4, 1, 0};  // single fault at code 4
        vecs[4] = '{16'h8001, 2, 0, 1, 0};  // faults at both ends

        // Reset state, before any clock edge.
        #3;
        check("rst_busy", busy0, 0);
        check("rst_drive", drv0, 0);
        check("rst_done", done0, 0);
        check("rst_pass", pass0, 0);
        check("rst_err", err0, 0);
        check("rst_ffv", ffv0, 0);
        check("rst_ffc", ffc0, 0);
        RESETB = 1'b1;
        tick();
        tick();

        // Table-driven full runs.
        for (int i = 0; i < 5; i++) begin
            run0(vecs[i].mask, (i == 0), -1, done_at);
            check($sformatf("v%0d_done_cycle", i), done_at, 81);
            check($sformatf("v%0d_err", i), err0, vecs[i].exp_err);
            check($sformatf("v%0d_ffv", i), ffv0, vecs[i].exp_valid);
            if (vecs[i].exp_valid != 0) check($sformatf("v%0d_ffc", i), ffc0, vecs[i].exp_first);
            check($sformatf("v%0d_pass", i), pass0, vecs[i].exp_pass);
            check($sformatf("v%0d_busy", i), busy0, 0);
            check($sformatf("v%0d_drive", i), drv0, 0);
            tick();
            check($sformatf("v%0d_done_pulse", i), done0, 0);
            check($sformatf("v%0d_pass_held", i), pass0, vecs[i].exp_pass);
        end

        // Randomized fault masks against the model.
        for (int r = 0; r < 16; r++) begin
            m = 16'($urandom);
            if ($urandom_range(0, 3) == 0) m = 16'h0000;
            model(m, e_err, e_first, e_valid);
            run0(m, 1'b0, -1, done_at);
            check($sformatf("rnd%0d_done_cycle", r), done_at, 81);
            check($sformatf("rnd%0d_err", r), err0, e_err);
            check($sformatf("rnd%0d_ffv", r), ffv0, e_valid);
            if (e_valid != 0) check($sformatf("rnd%0d_ffc", r), ffc0, e_first);
            check($sformatf("rnd%0d_pass", r), pass0, (e_err == 0) ? 1 : 0);
        end

        // START during a run is ignored.
        run0(16'h0000, 1'b0, 10, done_at);
        check("restart_done_cycle", done_at, 81);
        check("restart_pass", pass0, 1);

        // ABORT and START together in IDLE: stay idle.
        start0 = 1'b1;
        abort0 = 1'b1;
        tick();
        start0 = 1'b0;
        abort0 = 1'b0;
        check("abort_start_idle_busy", busy0, 0);
        tick();
        check("abort_start_idle_busy2", busy0, 0);

        // ABORT at cycle 20 with X stuck at 1: codes 0..3 already sampled.
        begin
            int dones;
            dones  = 0;
            xmask  = 16'h01FF;
            start0 = 1'b1;
            tick();
            start0 = 1'b0;
            for (int n = 1; n <= 120; n++) begin
                tick();
                if (done0) dones++;
                if (n == 20) abort0 = 1'b1;
                if (n == 21) begin
                    abort0 = 1'b0;
                    check("abort_busy", busy0, 0);
                    check("abort_drive", drv0, 0);
                end
            end
            check("abort_no_done", dones, 0);
            check("abort_pass", pass0, 0);
            check("abort_err_partial", err0, 4);
            check("abort_ffv", ffv0, 1);
            check("abort_ffc", ffc0, 0);
        end

        // Asynchronous reset mid-run, then a clean run.
        xmask  = 16'h01FF;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int n = 1; n <= 40; n++) tick();
        check("pre_reset_busy", busy0, 1);
        RESETB = 1'b0;
        #2;
        check("midrst_busy", busy0, 0);
        check("midrst_drive", drv0, 0);
        check("midrst_err", err0, 0);
        check("midrst_ffv", ffv0, 0);
        check("midrst_ffc", ffc0, 0);
        check("midrst_done", done0, 0);
        tick();
        RESETB = 1'b1;
        tick();
        run0(16'h0000, 1'b1, -1, done_at);
        check("postrst_done_cycle", done_at, 81);
        check("postrst_pass", pass0, 1);
        check("postrst_err", err0, 0);
        check("postrst_ffv", ffv0, 0);

        // Three loops with X stuck at 0; 4-bit counter saturates.
        begin
            int d3;
            d3 = -1;
            start_m = 1'b1;
            tick();
            start_m = 1'b0;
            for (int n = 1; n <= 400; n++) begin
                tick();
                if (done3) begin
                    d3 = n;
                    break;
                end
            end
            check("l3_done_cycle", d3, 241);
            check("l3_err", err3, 21);
            check("l3_ffc", ffc3, 9);
            check("l3_pass", pass3, 0);
            check("sat_done", done4, 1);
            check("sat_err", err4, 15);
            check("sat_pass", pass4, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
